// File: rtl/frame_rr_arbiter_if.sv
// AXI4-Stream bundle used on both sides of the frame arbiter.
// tuser marks start of frame, tlast marks end of line.
interface axi4_stream_if #(
   parameter int TDATA_WIDTH = 16
);
   logic                   tvalid;
   logic                   tready;
   logic [TDATA_WIDTH-1:0] tdata;
   logic                   tuser;
   logic                   tlast;

   modport master (output tvalid, output tdata, output tuser, output tlast, input tready);
   modport slave  (input tvalid, input tdata, input tuser, input tlast, output tready);
endinterface

// File: rtl/frame_rr_arbiter.sv
// Round-robin arbiter handing one shared video pipeline to a single source
// for a whole frame at a time; data path is a pure combinational mux.
//
// state   | meaning
// S_IDLE  | no owner; non-SOF beats flushed, SOF beats held as candidates
// S_GRANT | source sel_q owns video_o until FRAME_LINES lines have passed
module frame_rr_arbiter #(
   parameter int N_SRC          = 2,
   parameter int PX_WIDTH       = 10,
   parameter int TDATA_WIDTH    = ((PX_WIDTH + 7) / 8) * 8,
   parameter int FRAME_LINES    = 1080,
   parameter int LINE_CNT_WIDTH = $clog2(FRAME_LINES + 1)
) (
   input  logic             clk_i,
   input  logic             rst_i,
   axi4_stream_if.slave     video_i [N_SRC],
   axi4_stream_if.master    video_o,
   output logic [N_SRC-1:0] grant_o,
   output logic             sof_err_o
);

   localparam int SEL_W = $clog2(N_SRC);

   typedef enum logic {S_IDLE, S_GRANT} state_t;

   if (N_SRC < 2) begin : g_bad_nsrc
      $error("frame_rr_arbiter: N_SRC must be at least 2");
   end
   if (FRAME_LINES < 1) begin : g_bad_lines
      $error("frame_rr_arbiter: FRAME_LINES must be at least 1");
   end
   if (TDATA_WIDTH < PX_WIDTH) begin : g_bad_width
      $error("frame_rr_arbiter: TDATA_WIDTH narrower than PX_WIDTH");
   end

   state_t                    state_q, state_d;
   logic [SEL_W-1:0]          sel_q, sel_d;
   logic [SEL_W-1:0]          last_ptr_q, last_ptr_d;
   logic [N_SRC-1:0]          grant_q, grant_d;
   logic [LINE_CNT_WIDTH-1:0] line_cnt_q, line_cnt_d;
   logic                      mid_line_q, mid_line_d;
   logic                      sof_err_q, sof_err_d;

   logic [N_SRC-1:0]          src_tvalid, src_tuser, src_tlast, src_tready, cand;
   logic [TDATA_WIDTH-1:0]    src_tdata [N_SRC];

   logic                      out_tvalid, out_hs;
   logic                      found;
   logic [SEL_W-1:0]          pick, idx_s;
   logic [LINE_CNT_WIDTH-1:0] base_cnt;

   for (genvar g = 0; g < N_SRC; g++) begin : g_src
      assign src_tvalid[g]      = video_i[g].tvalid;
      assign src_tuser[g]       = video_i[g].tuser;
      assign src_tlast[g]       = video_i[g].tlast;
      assign src_tdata[g]       = video_i[g].tdata;
      assign video_i[g].tready  = src_tready[g];
   end

   assign cand = src_tvalid & src_tuser;

   assign out_tvalid    = (state_q == S_GRANT) && src_tvalid[sel_q];
   assign out_hs        = out_tvalid && video_o.tready;
   assign video_o.tvalid = out_tvalid;
   assign video_o.tdata  = src_tdata[sel_q];
   assign video_o.tuser  = src_tuser[sel_q];
   assign video_o.tlast  = src_tlast[sel_q];

   assign grant_o   = grant_q;
   assign sof_err_o = sof_err_q;

   // IDLE drains partial frames but holds SOF beats so the winner's SOF is not lost.
   always_comb begin
      src_tready = '0;
      for (int i = 0; i < N_SRC; i++) begin
         if (state_q == S_IDLE)
            src_tready[i] = src_tvalid[i] & ~src_tuser[i];
         else
            src_tready[i] = (sel_q == SEL_W'(i)) & video_o.tready;
      end
   end

   always_comb begin
      found = 1'b0;
      pick  = '0;
      idx_s = '0;
      for (int i = 1; i <= N_SRC; i++) begin
         idx_s = SEL_W'((int'(last_ptr_q) + i) % N_SRC);
         if (!found && cand[idx_s]) begin
            found = 1'b1;
            pick  = idx_s;
         end
      end
   end

   always_comb begin
      state_d    = state_q;
      sel_d      = sel_q;
      last_ptr_d = last_ptr_q;
      grant_d    = grant_q;
      line_cnt_d = line_cnt_q;
      mid_line_d = mid_line_q;
      sof_err_d  = 1'b0;
      base_cnt   = line_cnt_q;

      case (state_q)
         S_IDLE: begin
            if (found) begin
               sel_d      = pick;
               grant_d    = N_SRC'(1) << pick;
               line_cnt_d = '0;
               mid_line_d = 1'b0;
               state_d    = S_GRANT;
            end
         end
         S_GRANT: begin
            if (out_hs) begin
               // A fresh SOF restarts the line count; it is an error only if the old frame was unfinished.
               if (video_o.tuser) begin
                  base_cnt = '0;
                  if ((line_cnt_q != '0) || mid_line_q)
                     sof_err_d = 1'b1;
               end
               if (video_o.tlast) begin
                  mid_line_d = 1'b0;
                  if (base_cnt == LINE_CNT_WIDTH'(FRAME_LINES - 1)) begin
                     line_cnt_d = '0;
                     last_ptr_d = sel_q;
                     grant_d    = '0;
                     state_d    = S_IDLE;
                  end else begin
                     line_cnt_d = base_cnt + LINE_CNT_WIDTH'(1);
                  end
               end else begin
                  mid_line_d = 1'b1;
                  line_cnt_d = base_cnt;
               end
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         state_q    <= S_IDLE;
         sel_q      <= '0;
         last_ptr_q <= SEL_W'(N_SRC - 1);
         grant_q    <= '0;
         line_cnt_q <= '0;
         mid_line_q <= 1'b0;
         sof_err_q  <= 1'b0;
      end else begin
         state_q    <= state_d;
         sel_q      <= sel_d;
         last_ptr_q <= last_ptr_d;
         grant_q    <= grant_d;
         line_cnt_q <= line_cnt_d;
         mid_line_q <= mid_line_d;
         sof_err_q  <= sof_err_d;
      end
   end

endmodule

// File: tb/tb_frame_rr_arbiter.sv
// Bench for frame_rr_arbiter: IDLE vector table plus scoreboarded frame sequences.
module tb_frame_rr_arbiter;

   localparam int N_SRC = 2;
   localparam int FL    = 3;
   localparam int TDW   = 16;

   logic             clk = 1'b0;
   logic             rst = 1'b1;
   logic [N_SRC-1:0] grant;
   logic             sof_err;

   axi4_stream_if #(.TDATA_WIDTH(TDW)) src_if [N_SRC] ();
   axi4_stream_if #(.TDATA_WIDTH(TDW)) out_if ();

   frame_rr_arbiter #(
      .N_SRC(N_SRC), .PX_WIDTH(10), .TDATA_WIDTH(TDW), .FRAME_LINES(FL)
   ) dut (
      .clk_i(clk), .rst_i(rst), .video_i(src_if), .video_o(out_if),
      .grant_o(grant), .sof_err_o(sof_err)
   );

   always #5 clk = ~clk;

   typedef struct packed {
      logic [TDW-1:0] data;
      logic           user;
      logic           last;
   } beat_t;

   typedef struct {
      logic v0, u0, v1, u1;
      logic r0, r1;
      logic [1:0] g;
   } vec_t;

   beat_t      src_q0[$];
   beat_t      src_q1[$];
   beat_t      exp_q[$];
   logic [1:0] exp_grant_q[$];
   int         n_checks = 0;
   int         n_fail   = 0;
   bit         bp_en    = 0;
   int         sof_pulses = 0;
   int         flush_cnt  = 0;
   int         gc;
   vec_t       vecs [8];

   task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
      end
   endtask

   function automatic beat_t mk(input int src, input int id, input int line, input int px);
      beat_t b;
      b.data = TDW'(src * 16'h8000 + id * 16'h0400 + line * 16'h0010 + px);
      b.user = (line == 0) && (px == 0);
      b.last = (px == 3);
      return b;
   endfunction

   task automatic add_frame(input int src, input int id, input int lines);
      for (int l = 0; l < lines; l++)
         for (int p = 0; p < 4; p++)
            if (src == 0) src_q0.push_back(mk(src, id, l, p));
            else          src_q1.push_back(mk(src, id, l, p));
   endtask

   task automatic exp_frame(input int src, input int id, input int lines);
      for (int l = 0; l < lines; l++)
         for (int p = 0; p < 4; p++)
            exp_q.push_back(mk(src, id, l, p));
   endtask

   task automatic drive_inputs();
      beat_t b;
      src_if[0].tvalid = (src_q0.size() != 0);
      b = (src_q0.size() != 0) ? src_q0[0] : '0;
      src_if[0].tdata = b.data; src_if[0].tuser = b.user; src_if[0].tlast = b.last;
      src_if[1].tvalid = (src_q1.size() != 0);
      b = (src_q1.size() != 0) ? src_q1[0] : '0;
      src_if[1].tdata = b.data; src_if[1].tuser = b.user; src_if[1].tlast = b.last;
      out_if.tready = bp_en ? ($urandom_range(0, 2) != 0) : 1'b1;
   endtask

   task automatic pulse_reset();
      rst = 1'b1;
      @(posedge clk); #1;
      rst = 1'b0;
   endtask

   // Runs the scoreboard until all queues drain; optionally pulses reset after rst_hs output beats.
   task automatic run(input int budget, input int rst_hs, output int grant_cycle);
      int    hs_cnt = 0;
      bit    exp_err = 0, exp_rel = 0, rst_now = 0, rst_next = 0, rst_done = 0, done = 0;
      int    m_lines = 0;
      bit    m_mid = 0;
      logic [1:0] prev_grant = '0;
      beat_t e;
      grant_cycle = -1;
      for (int c = 0; c < budget; c++) begin
         drive_inputs();
         @(negedge clk);
         check("sof_err", sof_err, exp_err);
         if (sof_err) sof_pulses++;
         exp_err = 0;
         if (exp_rel) begin
            check("release_grant", grant, 0);
            check("release_tvalid", out_if.tvalid, 0);
            exp_rel = 0;
         end
         if (rst_now) begin
            check("rst_grant", grant, 0);
            check("rst_tvalid", out_if.tvalid, 0);
         end
         if (grant == 2'b00) check("idle_tvalid", out_if.tvalid, 0);
         if (grant != 2'b00 && prev_grant == 2'b00) begin
            if (grant_cycle < 0) grant_cycle = c;
            if (exp_grant_q.size() == 0) check("grant_unexpected", grant, 0);
            else check("grant", grant, exp_grant_q.pop_front());
            check("grant_sof_visible", out_if.tvalid && out_if.tuser, 1);
         end
         if (grant == 2'b01) check("nonowner_rdy1", src_if[1].tready, 0);
         if (grant == 2'b10) check("nonowner_rdy0", src_if[0].tready, 0);
         if (out_if.tvalid && out_if.tready) begin
            hs_cnt++;
            if (exp_q.size() == 0) begin
               check("beat_unexpected", out_if.tdata, 32'hFFFF_FFFF);
            end else begin
               e = exp_q.pop_front();
               check("beat", {out_if.tdata, out_if.tuser, out_if.tlast}, e);
               if (e.user && (m_lines != 0 || m_mid)) exp_err = 1;
               if (e.user) m_lines = 0;
               if (e.last) begin
                  m_lines++;
                  m_mid = 0;
                  if (m_lines == FL) begin m_lines = 0; exp_rel = 1; end
               end else m_mid = 1;
            end
         end
         if (src_if[0].tvalid && src_if[0].tready) begin
            if (grant == 2'b00) begin
               check("flush_no_sof0", src_if[0].tuser, 0);
               flush_cnt++;
            end
            void'(src_q0.pop_front());
         end
         if (src_if[1].tvalid && src_if[1].tready) begin
            if (grant == 2'b00) begin
               check("flush_no_sof1", src_if[1].tuser, 0);
               flush_cnt++;
            end
            void'(src_q1.pop_front());
         end
         prev_grant = grant;
         if (rst_hs > 0 && hs_cnt == rst_hs && !rst_done) begin
            rst_next = 1;
            rst_done = 1;
         end
         if (src_q0.size() == 0 && src_q1.size() == 0 && exp_q.size() == 0 &&
             exp_grant_q.size() == 0 && !exp_rel && !exp_err && !rst_now && !rst_next &&
             grant == 2'b00) begin
            done = 1;
            break;
         end
         @(posedge clk); #1;
         if (rst_now) begin
            rst = 1'b0;
            rst_now = 0;
         end else if (rst_next) begin
            rst = 1'b1;
            rst_now = 1;
            rst_next = 0;
            m_lines = 0; m_mid = 0; exp_err = 0; exp_rel = 0;
            prev_grant = '0;
         end
      end
      if (!done) check("run_timeout", 0, 1);
      @(posedge clk); #1;
      src_if[0].tvalid = 1'b0;
      src_if[1].tvalid = 1'b0;
   endtask

   initial begin
      vecs[0] = '{v0:0, u0:0, v1:0, u1:0, r0:0, r1:0, g:2'b00};
      vecs[1] = '{v0:1, u0:0, v1:0, u1:0, r0:1, r1:0, g:2'b00};
      vecs[2] = '{v0:1, u0:0, v1:1, u1:0, r0:1, r1:1, g:2'b00};
      vecs[3] = '{v0:1, u0:1, v1:0, u1:0, r0:0, r1:0, g:2'b01};
      vecs[4] = '{v0:0, u0:0, v1:1, u1:1, r0:0, r1:0, g:2'b10};
      vecs[5] = '{v0:1, u0:1, v1:1, u1:1, r0:0, r1:0, g:2'b01};
      vecs[6] = '{v0:1, u0:0, v1:1, u1:1, r0:1, r1:0, g:2'b10};
      vecs[7] = '{v0:1, u0:1, v1:1, u1:0, r0:0, r1:1, g:2'b01};

      src_if[0].tvalid = 0; src_if[0].tdata = '0; src_if[0].tuser = 0; src_if[0].tlast = 0;
      src_if[1].tvalid = 0; src_if[1].tdata = '0; src_if[1].tuser = 0; src_if[1].tlast = 0;
      out_if.tready = 1;
      repeat (2) @(posedge clk);
      #1 rst = 1'b0;
      @(negedge clk);
      check("reset_grant", grant, 0);
      check("reset_sof_err", sof_err, 0);
      check("reset_tvalid", out_if.tvalid, 0);
      check("reset_rdy", {src_if[1].tready, src_if[0].tready}, 0);
      @(posedge clk); #1;

      // IDLE-state ready/candidate table; reset before each row so last_ptr = 1.
      for (int i = 0; i < 8; i++) begin
         pulse_reset();
         src_if[0].tvalid = vecs[i].v0; src_if[0].tuser = vecs[i].u0; src_if[0].tlast = 0;
         src_if[1].tvalid = vecs[i].v1; src_if[1].tuser = vecs[i].u1; src_if[1].tlast = 0;
         out_if.tready = 1;
         @(negedge clk);
         check("vec_rdy0", src_if[0].tready, vecs[i].r0);
         check("vec_rdy1", src_if[1].tready, vecs[i].r1);
         check("vec_tvalid", out_if.tvalid, 0);
         @(posedge clk); #1;
         src_if[0].tvalid = 0;
         src_if[1].tvalid = 0;
         @(negedge clk);
         check("vec_grant", grant, vecs[i].g);
         @(posedge clk); #1;
      end

      // Single 3-line frame from source 0
      pulse_reset();
      add_frame(0, 1, FL); exp_frame(0, 1, FL); exp_grant_q.push_back(2'b01);
      run(200, 0, gc);
      check("grant_latency", gc, 1);

      // Simultaneous SOF, 4 frames alternate
      pulse_reset();
      add_frame(0, 2, FL); add_frame(0, 3, FL);
      add_frame(1, 2, FL); add_frame(1, 3, FL);
      exp_frame(0, 2, FL); exp_frame(1, 2, FL); exp_frame(0, 3, FL); exp_frame(1, 3, FL);
      exp_grant_q.push_back(2'b01); exp_grant_q.push_back(2'b10);
      exp_grant_q.push_back(2'b01); exp_grant_q.push_back(2'b10);
      run(400, 0, gc);

      // Source 1 mid-frame while IDLE: flushed, then granted on SOF
      pulse_reset();
      flush_cnt = 0;
      src_q1.push_back(mk(1, 4, 1, 1));
      src_q1.push_back(mk(1, 4, 1, 2));
      src_q1.push_back(mk(1, 4, 1, 3));
      add_frame(1, 5, FL); exp_frame(1, 5, FL); exp_grant_q.push_back(2'b10);
      run(200, 0, gc);
      check("flush_count", flush_cnt, 3);

      // Random output backpressure with both sources contending
      pulse_reset();
      bp_en = 1;
      add_frame(0, 6, FL); add_frame(1, 6, FL);
      exp_frame(0, 6, FL); exp_frame(1, 6, FL);
      exp_grant_q.push_back(2'b01); exp_grant_q.push_back(2'b10);
      run(600, 0, gc);
      bp_en = 0;

      // Early SOF after one line: one error pulse, frame restarts under the same owner
      pulse_reset();
      sof_pulses = 0;
      add_frame(0, 7, 1); add_frame(0, 8, FL);
      exp_frame(0, 7, 1); exp_frame(0, 8, FL);
      exp_grant_q.push_back(2'b01);
      run(200, 0, gc);
      check("sof_err_pulses", sof_pulses, 1);

      // Reset after 3 beats of a frame: remainder flushed, next frame granted
      pulse_reset();
      add_frame(0, 9, FL); add_frame(0, 10, FL);
      exp_q.push_back(mk(0, 9, 0, 0));
      exp_q.push_back(mk(0, 9, 0, 1));
      exp_q.push_back(mk(0, 9, 0, 2));
      exp_frame(0, 10, FL);
      exp_grant_q.push_back(2'b01); exp_grant_q.push_back(2'b01);
      flush_cnt = 0;
      run(300, 3, gc);
      check("rst_flush_count", flush_cnt, 9);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/frame_rr_arbiter.md
# frame_rr_arbiter

Round-robin arbiter that shares one AXI4-Stream video pipeline (line extender, frame extender and downstream filters) among several video sources. Ownership switches only on whole-frame boundaries, so the shared pipeline never sees lines from two sources interleaved. The block sits between the source interfaces and the head of the shared pipeline and adds no pipeline register on the data path.

## Interface
Parameters:
- N_SRC, 2, number of requesting sources; minimum 2.
- PX_WIDTH, 10, pixel width in bits.
- TDATA_WIDTH, PX_WIDTH rounded up to a multiple of 8, tdata width.
- FRAME_LINES, 1080, lines per frame; counted by tlast; minimum 1.
- LINE_CNT_WIDTH, $clog2(FRAME_LINES+1), line counter width; derived, do not override.

Ports:
- clk_i  in  1  clock.
- rst_i  in  1  reset, asynchronous, active-high.
- video_i  slave  axi4_stream_if[N_SRC]  source streams; tuser marks start of frame (SOF), tlast marks end of line.
- video_o  master  axi4_stream_if  stream to the shared pipeline.
- grant_o  out  N_SRC  one-hot owner; zero when idle.
- sof_err_o  out  1  one-cycle pulse when SOF is accepted mid-frame.

## Operation
- States: IDLE and GRANT.
- IDLE:
  - video_o.tvalid = 0.
  - Any source with tvalid=1 and tuser=0 gets tready=1. Mid-frame beats are flushed so a source resynchronises to its next SOF.
  - Sources presenting tvalid=1 and tuser=1 are candidates.
  - If at least one candidate exists, select the first one in round-robin order, starting at last_ptr+1 modulo N_SRC. Register the selection in sel, set grant_o, clear line_cnt and go to GRANT.
  - Candidates get tready=0 in IDLE, so the SOF beat is held and not consumed.
- GRANT:
  - video_o carries all fields of video_i[sel] combinationally.
  - video_i[sel].tready = video_o.tready.
  - All other sources get tready=0; they are not flushed.
  - On each handshake with tlast=1, line_cnt increments.
  - If that handshake has line_cnt == FRAME_LINES-1, the frame is complete: set last_ptr <= sel, grant_o <= 0, state <= IDLE.
  - SOF handshake with line_cnt != 0, or with a line partly sent: pulse sof_err_o and reset line_cnt to 0. The grant is kept and the new frame continues through the same owner.
  - If that SOF beat also has tlast=1, line_cnt becomes 1. If FRAME_LINES == 1, the frame completes normally.
- A source that stalls mid-frame keeps the grant indefinitely; the block has no timeout.
- Line position tracking: a mid_line flag is set on a non-tlast handshake and cleared on a tlast handshake. It is used only for the sof_err_o condition.
- Reset values:
  - state = IDLE, grant_o = 0, sel = 0, last_ptr = N_SRC-1 (source 0 has first priority).
  - line_cnt = 0, mid_line = 0, sof_err_o = 0.
  - video_o.tvalid = 0. All video_i tready follow the IDLE rules.
- Reset mid-frame: the block returns to IDLE immediately. The rest of the interrupted frame is flushed as non-SOF beats.

## Timing
- Arbitration latency:
  - SOF visible in cycle N gives grant_o set in cycle N+1.
  - The SOF beat appears on video_o in cycle N+1 and transfers in N+1 if video_o.tready=1.
- The data path is zero-latency in GRANT: tvalid, tdata and tready are combinational through the mux.
- Frame completion: the final tlast handshake in cycle M gives IDLE in M+1, with video_o.tvalid=0 in M+1. The next grant is no earlier than M+2.
- There is at least one idle cycle between frames; no back-to-back frames across owners.
- A simultaneous SOF from several sources is resolved only by the round-robin order above.
- A source that reasserts SOF in the same cycle the frame completes is not granted until IDLE evaluates it in M+1.
- sof_err_o is registered and asserted for the cycle after the offending handshake.

## Test plan
- Reset, then source 0 sends a 3-line frame (FRAME_LINES=3, 4 px per line) -> grant_o=01 one cycle after SOF; 12 beats pass unchanged; grant_o=00 the cycle after the third tlast.
- Both sources present SOF in the same cycle, repeated over 4 frames -> grants alternate 01, 10, 01, 10; each output frame contains only one source's data.
- Source 1 is mid-frame (tuser=0) while IDLE -> its beats are flushed with tready=1 and video_o.tvalid=0; it is granted on its next SOF.
- Random video_o.tready backpressure during GRANT -> every beat is preserved in order; the non-owner's tready stays 0 throughout.
- Owner sends SOF after 1 complete line -> sof_err_o pulses once; line_cnt restarts; the grant is released after 3 more lines.
- rst_i asserted for 1 cycle mid-line -> grant_o=0 and video_o.tvalid=0 immediately; the rest of the frame is flushed; the next SOF is granted normally.
